// File: rtl/step_cmd_sched.sv
// step_cmd_sched: FIFO-buffered command scheduler feeding the stepper pulse generator; define STEP_POS_TRACK_EN to add the position counter (pos, pos_clr)
module step_cmd_sched #(
  parameter int FIFO_AW    = 3,
  parameter int WR_LOW_CYC = 2,
  parameter int BUSY_TO    = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               start,
  input  logic               abort,
  output logic [7:0]         gen_n,
  output logic               gen_wr_n,
  input  logic               gen_busy,
  input  logic               gen_pulse,
`ifdef STEP_POS_TRACK_EN
  output logic signed [15:0] pos,
  input  logic               pos_clr,
`endif
  output logic               running,
  output logic               done,
  output logic               fault,
  output logic [FIFO_AW:0]   level
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW = $clog2(BUSY_TO + WR_LOW_CYC + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, STOP} state_t;
  state_t state, nxt;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic last_dir, push, pop, empty, fault_set, done_set;
  assign empty = level == '0;
  assign cmd_ready = level != (FIFO_AW + 1)'(DEPTH);
  assign push = cmd_valid && cmd_ready && state != STOP && !abort;
  assign pop = nxt == ISSUE && state != ISSUE;
  // command storage; written on push only, so no reset needed
  always_ff @(posedge clk)
    if (push) mem[wp] <= cmd_data;
  // FIFO pointers and occupancy; any abort flushes, a pop happens on ISSUE entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (abort) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    end
  // next-state decode; abort wins over everything and restarts the strobe count
  always_comb begin
    nxt = state;
    fault_set = 1'b0;
    done_set = 1'b0;
    if (abort) nxt = state == IDLE ? IDLE : STOP;
    else
      case (state)
        IDLE: nxt = start && !empty ? ISSUE : IDLE;
        ISSUE: nxt = cnt == CW'(WR_LOW_CYC - 1) ? WAIT_BUSY : ISSUE;
        WAIT_BUSY: begin
          fault_set = !gen_busy && cnt == CW'(BUSY_TO);
          nxt = gen_busy ? RUN : fault_set ? IDLE : WAIT_BUSY;
        end
        RUN: begin
          done_set = !gen_busy && empty;
          nxt = gen_busy ? RUN : empty ? IDLE : ISSUE;
        end
        STOP: nxt = cnt == CW'(WR_LOW_CYC - 1) ? IDLE : STOP;
        default: nxt = IDLE;
      endcase
    cnt_nxt = nxt != state || abort ? '0 : cnt + 1'b1;
  end
  // state register and registered generator-facing outputs, decoded from next state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      gen_n <= '0;
      gen_wr_n <= 1'b1;
      running <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      last_dir <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      gen_wr_n <= !(nxt == ISSUE || nxt == STOP);
      running <= nxt != IDLE;
      done <= done_set;
      fault <= fault_set || (fault && !(state == IDLE && start && !abort));
      if (pop) begin
        gen_n <= mem[rp];
        last_dir <= mem[rp][7];
      end else if (nxt == STOP && state != STOP) gen_n <= {last_dir, 7'd0};
    end
`ifdef STEP_POS_TRACK_EN
  logic pulse_q;
  // signed position: one step per gen_pulse rising edge in the direction last issued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pulse_q <= 1'b0;
      pos <= '0;
    end else begin
      pulse_q <= gen_pulse;
      if (pos_clr) pos <= '0;
      else if (gen_pulse && !pulse_q) pos <= last_dir ? pos + 16'sd1 : pos - 16'sd1;
    end
`else
  logic unused_pulse;
  assign unused_pulse = gen_pulse;
`endif
endmodule

// File: tb/tb_step_cmd_sched.sv
// tb_step_cmd_sched: self-checking bench for step_cmd_sched with a behavioural generator model
module tb_step_cmd_sched;
  localparam int BUSY_TO = 15;
  localparam int WR_LOW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] cmd_data = '0;
  logic cmd_valid = 1'b0, start = 1'b0, abort = 1'b0, gen_busy = 1'b0, gen_pulse = 1'b0;
  logic cmd_ready, gen_wr_n, running, done, fault;
  logic [7:0] gen_n;
  logic [3:0] level;
`ifdef STEP_POS_TRACK_EN
  logic signed [15:0] pos;
  logic pos_clr = 1'b0;
`endif
  int checks = 0, errors = 0;
  always #25 clk = ~clk;
  step_cmd_sched dut (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .start(start), .abort(abort), .gen_n(gen_n), .gen_wr_n(gen_wr_n), .gen_busy(gen_busy),
    .gen_pulse(gen_pulse),
`ifdef STEP_POS_TRACK_EN
    .pos(pos), .pos_clr(pos_clr),
`endif
    .running(running), .done(done), .fault(fault), .level(level)
  );
  // generator model: after each strobe ends, wait gen_lat cycles then stay busy busy_len cycles
  int gen_lat = 3, busy_len = 200, n_pulses = 0, g_wait = 0, g_left = 0, p_left = 0;
  bit gen_on = 1'b1;
  logic g_prev = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      gen_busy = 1'b0; gen_pulse = 1'b0; g_wait = 0; g_left = 0; p_left = 0; g_prev = 1'b1;
    end else begin
      gen_pulse = 1'b0;
      if (gen_busy) begin
        g_left--;
        if (g_left == 0) gen_busy = 1'b0;
        else if (g_left % 2 == 0 && p_left > 0) begin gen_pulse = 1'b1; p_left--; end
      end else if (g_wait > 0) begin
        g_wait--;
        if (g_wait == 0) begin gen_busy = 1'b1; g_left = busy_len; end
      end
      if (gen_on && gen_wr_n && !g_prev) begin g_wait = gen_lat; p_left = n_pulses; end
      g_prev = gen_wr_n;
    end
  end
  // strobe monitor: records value, low width, stability and start cycle of every strobe
  typedef struct {logic [7:0] val; int len; bit stable; int t;} strobe_t;
  strobe_t strobes[$];
  strobe_t cur;
  int cyc = 0, done_cnt = 0;
  logic m_prev = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) m_prev = 1'b1;
    else begin
      if (!gen_wr_n) begin
        if (m_prev) begin cur.val = gen_n; cur.len = 0; cur.stable = 1'b1; cur.t = cyc; end
        else if (gen_n !== cur.val) cur.stable = 1'b0;
        cur.len++;
      end else if (!m_prev) strobes.push_back(cur);
      if (done) done_cnt++;
      m_prev = gen_wr_n;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic push(input logic [7:0] d);
    cmd_data = d; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask
  task automatic settle(input string nm);
    int n = 0;
    while ((running || gen_busy || g_wait != 0) && n < 3000) begin tick(); n++; end
    chk({nm, " settle"}, n < 3000, 1);
  endtask
  task automatic wait_done(input int tgt, input string nm);
    int n = 0;
    while (done_cnt < tgt && n < 5000) begin tick(); n++; end
    chk({nm, " done reached"}, done_cnt >= tgt, 1);
  endtask
  task automatic wait_strobes(input int tgt, input string nm);
    int n = 0;
    while (strobes.size() < tgt && n < 3000) begin tick(); n++; end
    chk({nm, " strobe reached"}, strobes.size() >= tgt, 1);
  endtask
  // random round: model queue in push order; the DUT must issue exactly that order
  task automatic rnd_round(input int r);
    logic [7:0] exp_q[$];
    int n, pushed, base, d0, starts, guard, pend;
    n = $urandom_range(1, 8);
    pushed = 0; base = strobes.size(); d0 = done_cnt; starts = 0; guard = 0;
    gen_lat = $urandom_range(1, 8);
    busy_len = $urandom_range(2, 40);
    while ((pushed < n || strobes.size() - base < n || running) && guard < 6000) begin
      cmd_valid = 1'b0; start = 1'b0;
      if (!running) begin
        pend = pushed - (strobes.size() - base);
        chk($sformatf("rnd%0d idle level", r), level, pend);
        if (pend > 0) begin start = 1'b1; starts++; end
      end
      if (pushed < n && $urandom_range(0, 2) == 0) begin
        cmd_data = 8'($urandom); cmd_valid = 1'b1; exp_q.push_back(cmd_data); pushed++;
      end
      tick(); guard++;
    end
    cmd_valid = 1'b0; start = 1'b0;
    chk($sformatf("rnd%0d finished", r), guard < 6000, 1);
    chk($sformatf("rnd%0d strobe count", r), strobes.size() - base, n);
    for (int i = 0; i < n && base + i < strobes.size(); i++) begin
      chk($sformatf("rnd%0d cmd%0d value", r, i), strobes[base + i].val, exp_q[i]);
      chk($sformatf("rnd%0d cmd%0d width", r, i), strobes[base + i].len, WR_LOW);
      chk($sformatf("rnd%0d cmd%0d stable", r, i), strobes[base + i].stable, 1);
    end
    chk($sformatf("rnd%0d done pulses", r), done_cnt - d0, starts);
    chk($sformatf("rnd%0d fault", r), fault, 0);
  endtask
  typedef struct {logic [7:0] d; logic v, st, ab; logic [3:0] lvl; logic rdy;} vec_t;
  vec_t tbl[14];
  initial begin
    int b, d0, n;
    for (int i = 0; i < 9; i++) begin
      tbl[i].d = 8'h11 + 8'(i); tbl[i].v = 1'b1; tbl[i].st = 1'b0; tbl[i].ab = 1'b0;
      tbl[i].lvl = i < 8 ? 4'(i + 1) : 4'd8;
      tbl[i].rdy = tbl[i].lvl != 4'd8;
    end
    tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1};
    tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
    tbl[11] = '{8'h42, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    tbl[12] = '{8'h00, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
    tick(3);
    chk("reset gen_n", gen_n, 0);
    chk("reset gen_wr_n", gen_wr_n, 1);
    chk("reset running", running, 0);
    chk("reset done", done, 0);
    chk("reset fault", fault, 0);
    chk("reset level", level, 0);
    chk("reset cmd_ready", cmd_ready, 1);
`ifdef STEP_POS_TRACK_EN
    chk("reset pos", pos, 0);
`endif
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 14; i++) begin
      cmd_data = tbl[i].d; cmd_valid = tbl[i].v; start = tbl[i].st; abort = tbl[i].ab;
      tick();
      cmd_valid = 1'b0; start = 1'b0; abort = 1'b0;
      chk($sformatf("tbl%0d level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d cmd_ready", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d running", i), running, 0);
      chk($sformatf("tbl%0d gen_wr_n", i), gen_wr_n, 1);
      chk($sformatf("tbl%0d done", i), done, 0);
    end
    chk("tbl no strobes", strobes.size(), 0);
    chk("tbl no done", done_cnt, 0);
    gen_lat = 3; busy_len = 200;
    push(8'h85); push(8'h0A); pulse_start();
    chk("basic first gen_n", gen_n, 8'h85);
    chk("basic first wr_n low", gen_wr_n, 0);
    chk("basic level after pop", level, 1);
    wait_done(1, "basic");
    chk("basic strobe count", strobes.size(), 2);
    if (strobes.size() == 2) begin
      chk("basic s0 value", strobes[0].val, 8'h85);
      chk("basic s0 width", strobes[0].len, WR_LOW);
      chk("basic s1 value", strobes[1].val, 8'h0A);
      chk("basic s1 width", strobes[1].len, WR_LOW);
      chk("basic issue spacing", strobes[1].t - strobes[0].t, WR_LOW + 3 + 200 + 1);
    end
    chk("basic level end", level, 0);
    chk("basic running end", running, 0);
    tick(5);
    chk("basic single done", done_cnt, 1);
    gen_lat = 1; busy_len = 4;
    b = strobes.size(); d0 = done_cnt;
    for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
    chk("full level", level, 8);
    chk("full cmd_ready", cmd_ready, 0);
    pulse_start();
    wait_done(d0 + 1, "full");
    chk("full strobe count", strobes.size() - b, 8);
    for (int i = 0; i < 8 && b + i < strobes.size(); i++)
      chk($sformatf("full cmd%0d", i), strobes[b + i].val, 8'hA0 + 8'(i));
    settle("full");
    gen_on = 1'b0;
    b = strobes.size(); d0 = done_cnt;
    push(8'h11); push(8'h22); push(8'h33); pulse_start();
    n = 0;
    while (!gen_wr_n && n < 20) begin tick(); n++; end
    tick(BUSY_TO);
    chk("timeout fault before limit", fault, 0);
    chk("timeout running before limit", running, 1);
    tick();
    chk("timeout fault set", fault, 1);
    chk("timeout running", running, 0);
    chk("timeout level kept", level, 2);
    tick(3);
    chk("timeout fault sticky", fault, 1);
    gen_on = 1'b1;
    pulse_start();
    chk("fault cleared by start", fault, 0);
    chk("restart running", running, 1);
    wait_done(d0 + 1, "after fault");
    chk("after fault strobes", strobes.size() - b, 3);
    if (strobes.size() - b == 3) begin
      chk("after fault cmd1", strobes[b + 1].val, 8'h22);
      chk("after fault cmd2", strobes[b + 2].val, 8'h33);
    end
    settle("fault");
    busy_len = 50; gen_lat = 2;
    b = strobes.size(); d0 = done_cnt;
    push(8'h90); push(8'h20); push(8'h30); pulse_start();
    n = 0;
    while (!gen_busy && n < 50) begin tick(); n++; end
    tick(5);
    chk("abort in run", running, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort gen_n", gen_n, 8'h80);
    chk("abort wr_n low", gen_wr_n, 0);
    chk("abort flushed", level, 0);
    push(8'h55);
    settle("abort");
    chk("abort push ignored", level, 0);
    chk("abort no done", done_cnt, d0);
    chk("abort running", running, 0);
    chk("abort strobes", strobes.size() - b, 2);
    if (strobes.size() - b == 2) begin
      chk("abort s0", strobes[b].val, 8'h90);
      chk("abort s1", strobes[b + 1].val, 8'h80);
      chk("abort s1 width", strobes[b + 1].len, WR_LOW);
    end
`ifdef STEP_POS_TRACK_EN
    busy_len = 20; gen_lat = 2; n_pulses = 3;
    pos_clr = 1'b1; tick(); pos_clr = 1'b0;
    chk("pos cleared", pos, 0);
    b = strobes.size(); d0 = done_cnt;
    push(8'h83); push(8'h03); pulse_start();
    wait_strobes(b + 2, "pos");
    chk("pos after fwd", pos, 3);
    wait_done(d0 + 1, "pos");
    tick(2);
    chk("pos after rev", pos, 0);
    push(8'h85); pulse_start();
    n = 0;
    while (pos == 0 && n < 100) begin tick(); n++; end
    pos_clr = 1'b1; tick(); pos_clr = 1'b0;
    chk("pos_clr mid run", pos, 0);
    settle("pos");
    n_pulses = 0;
`endif
    for (int r = 0; r < 25; r++) rnd_round(r);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1);
  end
endmodule
